// File: rtl/sprite_frame_rom_pkg.sv
// Shared definitions for the sprite frame ROM: sprite address geometry, colour width,
// the transparent key colour and the {y,x} pixel address packing helper.
package sprite_frame_rom_pkg;

  localparam int SPRITE_AX  = 6;
  localparam int SPRITE_AY  = 6;
  localparam int SPRITE_AW  = SPRITE_AX + SPRITE_AY;
  localparam int FRAME_BITS = 2;
  localparam int RGB_W      = 12;

  // Colour key that downstream blending treats as transparent; passed through untouched here.
  localparam logic [RGB_W-1:0] ALPHA = 12'hF0F;

  function automatic logic [SPRITE_AW-1:0] pack_addr(input logic [SPRITE_AY-1:0] y,
                                                     input logic [SPRITE_AX-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/sprite_frame_rom_bram.sv
// Single-port-write, registered-read-port block RAM holding every sprite frame.
// Read-first on address collision; INIT_FILE is accepted for interface compatibility.
module sprite_bram #(
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking assignment samples mem before this cycle's write lands, giving read-first.
  always_ff @(posedge pclk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_frame_rom.sv
// Animated sprite pixel server: answers {rect_y, rect_x} reads one pclk later from the
// currently displayed frame, stepping frames only on vsync boundaries.
module sprite_frame_rom
  import sprite_frame_rom_pkg::*;
#(
  parameter int ADDR_WIDTH_X = SPRITE_AX,
  parameter int ADDR_WIDTH_Y = SPRITE_AY,
  parameter int FRAME_BITS   = sprite_frame_rom_pkg::FRAME_BITS,
  parameter int FRAMES       = 4,
  parameter int FRAME_PERIOD = 8,
  parameter     INIT_FILE    = ""
) (
  input  logic                                 pclk,
  input  logic                                 rst,
  input  logic                                 vsync_in,
  input  logic                                 anim_en,
  input  logic                                 anim_restart,
  input  logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] pixel_addr,
  output logic [RGB_W-1:0]                     rgb_pixel,
  output logic [FRAME_BITS-1:0]                frame_idx,
  output logic                                 anim_wrap,
  input  logic                                 wr_en,
  input  logic [FRAME_BITS-1:0]                wr_frame,
  input  logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] wr_addr,
  input  logic [RGB_W-1:0]                     wr_data
);

  localparam int AW    = ADDR_WIDTH_X + ADDR_WIDTH_Y;
  localparam int MEM_W = FRAME_BITS + AW;
  localparam int CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  localparam logic [CNT_W-1:0]      LAST_COUNT = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [FRAME_BITS-1:0] LAST_FRAME = FRAME_BITS'(FRAMES - 1);
  localparam logic [FRAME_BITS:0]   NUM_FRAMES = (FRAME_BITS + 1)'(FRAMES);

  logic             vsync_prev;
  logic             vsync_tick;
  logic [CNT_W-1:0] period_cnt;
  logic             wr_ok;

  assign vsync_tick = vsync_in & ~vsync_prev;
  // Writes aimed at frame slots beyond FRAMES are dropped rather than aliased.
  assign wr_ok      = wr_en && ({1'b0, wr_frame} < NUM_FRAMES);

  always_ff @(posedge pclk) begin
    if (rst) begin
      // vsync may already be high at release; starting "high" suppresses a false edge.
      vsync_prev <= 1'b1;
      period_cnt <= '0;
      frame_idx  <= '0;
      anim_wrap  <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      anim_wrap  <= 1'b0;
      if (anim_restart) begin
        period_cnt <= '0;
        frame_idx  <= '0;
      end else if (vsync_tick && anim_en) begin
        if (period_cnt == LAST_COUNT) begin
          period_cnt <= '0;
          if (frame_idx == LAST_FRAME) begin
            frame_idx <= '0;
            anim_wrap <= 1'b1;
          end else begin
            frame_idx <= frame_idx + FRAME_BITS'(1);
          end
        end else begin
          period_cnt <= period_cnt + CNT_W'(1);
        end
      end
    end
  end

  // frame_idx is the registered value, so a read on the change cycle still sees the old frame.
  sprite_bram #(
    .DATA_W    (RGB_W),
    .ADDR_W    (MEM_W),
    .INIT_FILE (INIT_FILE)
  ) u_bram (
    .pclk  (pclk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr ({wr_frame, wr_addr}),
    .wdata (wr_data),
    .raddr ({frame_idx, pixel_addr}),
    .rdata (rgb_pixel)
  );

endmodule

// File: tb/tb_sprite_frame_rom.sv
// Directed testbench for sprite_frame_rom (FRAMES=4, FRAME_PERIOD=2) with hand-computed expectations.
module tb_sprite_frame_rom;
  import sprite_frame_rom_pkg::*;

  logic                 pclk = 1'b0;
  logic                 rst;
  logic                 vsync_in;
  logic                 anim_en;
  logic                 anim_restart;
  logic [SPRITE_AW-1:0] pixel_addr;
  logic [RGB_W-1:0]     rgb_pixel;
  logic [1:0]           frame_idx;
  logic                 anim_wrap;
  logic                 wr_en;
  logic [1:0]           wr_frame;
  logic [SPRITE_AW-1:0] wr_addr;
  logic [RGB_W-1:0]     wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wraps    = 0;

  sprite_frame_rom #(
    .ADDR_WIDTH_X (6),
    .ADDR_WIDTH_Y (6),
    .FRAME_BITS   (2),
    .FRAMES       (4),
    .FRAME_PERIOD (2),
    .INIT_FILE    ("")
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .anim_en      (anim_en),
    .anim_restart (anim_restart),
    .pixel_addr   (pixel_addr),
    .rgb_pixel    (rgb_pixel),
    .frame_idx    (frame_idx),
    .anim_wrap    (anim_wrap),
    .wr_en        (wr_en),
    .wr_frame     (wr_frame),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    step();
    if (anim_wrap) wraps++;
    vsync_in = 1'b0;
    step();
    if (anim_wrap) wraps++;
  endtask

  task automatic write_mem(input logic [1:0] f, input logic [SPRITE_AW-1:0] a,
                           input logic [RGB_W-1:0] d);
    wr_en = 1'b1; wr_frame = f; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic restart();
    anim_restart = 1'b1;
    step();
    anim_restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync_in = 1'b1;
    step(); step();
    n_checks++;
    if (rgb_pixel !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", rgb_pixel); end
    n_checks++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL reset_frame got %0d want 0", frame_idx); end
    n_checks++;
    if (anim_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b want 0", anim_wrap); end
    // Release with vsync high: no edge; one real edge then only makes count 1.
    rst = 1'b0;
    step(); step();
    vsync_in = 1'b0;
    step();
    vsync_pulse();
    n_checks++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL reset_no_edge got %0d want 0", frame_idx); end
    restart();
  endtask

  task automatic test_write_read();
    write_mem(2'd0, pack_addr(6'd1, 6'd1), 12'h111);
    write_mem(2'd1, pack_addr(6'd1, 6'd1), 12'hF80);
    vsync_pulse();
    vsync_pulse();
    n_checks++;
    if (frame_idx !== 2'd1) begin n_fail++; $display("FAIL wr_rd_frame got %0d want 1", frame_idx); end
    pixel_addr = 12'h041;
    step();
    n_checks++;
    if (rgb_pixel !== 12'hF80) begin n_fail++; $display("FAIL wr_rd_data got %h want F80", rgb_pixel); end
  endtask

  task automatic test_pipelined();
    for (int i = 0; i < 64; i++) write_mem(2'd1, 12'h080 + 12'(i), 12'h300 + 12'(i));
    for (int i = 0; i < 64; i++) begin
      pixel_addr = 12'h080 + 12'(i);
      step();
      n_checks++;
      if (rgb_pixel !== 12'h300 + 12'(i)) begin
        n_fail++;
        $display("FAIL pipe_read[%0d] got %h want %h", i, rgb_pixel, 12'h300 + 12'(i));
      end
    end
  endtask

  task automatic test_frame_boundary();
    restart();
    pixel_addr = 12'h041;
    vsync_pulse();
    vsync_in = 1'b1;
    step();
    n_checks++;
    if (rgb_pixel !== 12'h111) begin n_fail++; $display("FAIL boundary_old_frame got %h want 111", rgb_pixel); end
    n_checks++;
    if (frame_idx !== 2'd1) begin n_fail++; $display("FAIL boundary_frame got %0d want 1", frame_idx); end
    vsync_in = 1'b0;
    step();
    n_checks++;
    if (rgb_pixel !== 12'hF80) begin n_fail++; $display("FAIL boundary_new_frame got %h want F80", rgb_pixel); end
  endtask

  task automatic test_advance();
    logic [1:0] exp_f;
    restart();
    wraps = 0;
    for (int s = 1; s <= 4; s++) begin
      vsync_pulse();
      vsync_pulse();
      exp_f = 2'(s);
      n_checks++;
      if (frame_idx !== exp_f) begin n_fail++; $display("FAIL advance_step%0d got %0d want %0d", s, frame_idx, exp_f); end
      n_checks++;
      if (wraps !== ((s == 4) ? 1 : 0)) begin
        n_fail++; $display("FAIL advance_wrap_step%0d got %0d want %0d", s, wraps, (s == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_anim_en();
    restart();
    vsync_pulse();
    anim_en = 1'b0;
    for (int i = 0; i < 5; i++) vsync_pulse();
    n_checks++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL hold_frame got %0d want 0", frame_idx); end
    anim_en = 1'b1;
    vsync_pulse();
    n_checks++;
    if (frame_idx !== 2'd1) begin n_fail++; $display("FAIL hold_resume got %0d want 1", frame_idx); end
  endtask

  task automatic test_restart();
    restart();
    for (int i = 0; i < 7; i++) vsync_pulse();
    n_checks++;
    if (frame_idx !== 2'd3) begin n_fail++; $display("FAIL restart_setup got %0d want 3", frame_idx); end
    // Next tick would wrap 3->0 and pulse anim_wrap; restart must win.
    vsync_in = 1'b1; anim_restart = 1'b1;
    step();
    n_checks++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL restart_frame got %0d want 0", frame_idx); end
    n_checks++;
    if (anim_wrap !== 1'b0) begin n_fail++; $display("FAIL restart_wrap got %b want 0", anim_wrap); end
    vsync_in = 1'b0; anim_restart = 1'b0;
    step();
    vsync_pulse();
    n_checks++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL restart_count got %0d want 0", frame_idx); end
    vsync_pulse();
    n_checks++;
    if (frame_idx !== 2'd1) begin n_fail++; $display("FAIL restart_resume got %0d want 1", frame_idx); end
  endtask

  task automatic test_same_cycle();
    restart();
    write_mem(2'd0, 12'h0C3, 12'h123);
    pixel_addr = 12'h0C3;
    write_mem(2'd0, 12'h0C3, 12'h0F0);
    n_checks++;
    if (rgb_pixel !== 12'h123) begin n_fail++; $display("FAIL collide_old got %h want 123", rgb_pixel); end
    step();
    n_checks++;
    if (rgb_pixel !== 12'h0F0) begin n_fail++; $display("FAIL collide_new got %h want 0F0", rgb_pixel); end
  endtask

  task automatic test_rst_mid();
    restart();
    vsync_pulse();
    vsync_pulse();
    pixel_addr = 12'h041;
    step();
    n_checks++;
    if (rgb_pixel !== 12'hF80) begin n_fail++; $display("FAIL rstmid_pre got %h want F80", rgb_pixel); end
    rst = 1'b1;
    step();
    n_checks++;
    if (rgb_pixel !== 12'h000) begin n_fail++; $display("FAIL rstmid_rgb got %h want 000", rgb_pixel); end
    n_checks++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL rstmid_frame got %0d want 0", frame_idx); end
    rst = 1'b0;
    step();
    n_checks++;
    if (rgb_pixel !== 12'h111) begin n_fail++; $display("FAIL rstmid_post got %h want 111", rgb_pixel); end
  endtask

  initial begin
    rst = 1'b1; vsync_in = 1'b0; anim_en = 1'b1; anim_restart = 1'b0;
    pixel_addr = '0; wr_en = 1'b0; wr_frame = '0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_write_read();
    test_pipelined();
    test_frame_boundary();
    test_advance();
    test_anim_en();
    test_restart();
    test_same_cycle();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
